// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature step decoder: resolution modes, Gray states
// and the transition classifier used by the decode stage.
package quad_pkg;

  localparam int X1 = 1;
  localparam int X2 = 2;
  localparam int X4 = 4;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  typedef enum logic [1:0] {
    TR_NONE    = 2'd0,
    TR_FWD     = 2'd1,
    TR_REV     = 2'd2,
    TR_ILLEGAL = 2'd3
  } trans_t;

  // Position of a state along the forward cycle 00->01->11->10.
  function automatic logic [1:0] gray_pos(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    d = gray_pos(cur) - gray_pos(prev);
    case (d)
      2'd0:    return TR_NONE;
      2'd1:    return TR_FWD;
      2'd3:    return TR_REV;
      default: return TR_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/quad_chan_filter.sv
// One encoder channel: two-flop synchroniser followed by a stability filter that
// only moves filt after the synchronised value has held for FILT_LEN cycles.
module quad_chan_filter
  import quad_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam logic [7:0] CNT_LAST = 8'(FILT_LEN - 1);

  logic       s1;
  logic       s2;
  logic       cand;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cand <= 1'b0;
      cnt  <= 8'd0;
      filt <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any disagreement with the candidate restarts the stability count.
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= 8'd0;
      end else if (cand != filt) begin
        if (cnt == CNT_LAST) begin
          filt <= cand;
          cnt  <= 8'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= 8'd0;
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature front end: filters A/B, decodes Gray transitions into step/dir for an
// up/down counter and flags transitions where both channels move at once.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int FILT_LEN = 4,
  parameter int X_MODE   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  input  logic b_in,
  input  logic clr_err,
  output logic step,
  output logic dir,
  output logic err,
  output logic err_sticky
);

  if (!(X_MODE == X1 || X_MODE == X2 || X_MODE == X4)) begin : g_bad_x_mode
    $error("quad_step_decoder: X_MODE must be 1, 2 or 4");
  end
  if (FILT_LEN < 1 || FILT_LEN > 255) begin : g_bad_filt_len
    $error("quad_step_decoder: FILT_LEN must be in 1..255");
  end

  // Covers the pipeline from reset-value filters to the real encoder position.
  localparam int SETTLE = FILT_LEN + 4;
  localparam int SW     = $clog2(SETTLE + 1);

  logic          filt_a;
  logic          filt_b;
  logic [1:0]    cur;
  logic [1:0]    prev;
  trans_t        trans;
  logic          qualify;
  logic          settled;
  logic [SW-1:0] settle_cnt;

  quad_chan_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk  (clk),
    .rst  (rst),
    .raw  (a_in),
    .filt (filt_a)
  );

  quad_chan_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk  (clk),
    .rst  (rst),
    .raw  (b_in),
    .filt (filt_b)
  );

  assign cur     = {filt_a, filt_b};
  assign settled = (settle_cnt == SW'(SETTLE));

  always_comb begin
    trans   = classify(prev, cur);
    qualify = 1'b0;
    if (X_MODE == X4) begin
      qualify = 1'b1;
    end else if (X_MODE == X2) begin
      qualify = prev[1] ^ cur[1];
    end else begin
      // X1 counts the 10<->00 edge only, so both directions hit the same spot.
      qualify = (prev == S10 && cur == S00) || (prev == S00 && cur == S10);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= S00;
      settle_cnt <= '0;
      step       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      dir        <= 1'b1;
    end else begin
      prev <= cur;
      step <= 1'b0;
      err  <= 1'b0;
      if (!settled) settle_cnt <= settle_cnt + SW'(1);
      if (clr_err) err_sticky <= 1'b0;
      if (settled) begin
        case (trans)
          TR_FWD: begin
            dir  <= 1'b1;
            step <= qualify;
          end
          TR_REV: begin
            dir  <= 1'b0;
            step <= qualify;
          end
          TR_ILLEGAL: begin
            err        <= 1'b1;
            err_sticky <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: an X4 and an X1 instance share the same
// encoder stimulus; pulses are counted on the falling edge.
module tb_quad_step_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_in = 1'b0;
  logic b_in = 1'b0;
  logic clr_err = 1'b0;
  logic step4, dir4, err4, errs4;
  logic step1, dir1, err1, errs1;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int steps4 = 0, errcnt4 = 0, steps1 = 0, errcnt1 = 0;
  int last_step4 = 0, last_err4 = 0;
  logic [3:0] q4 = 4'd0;
  logic filt_a_seen = 1'b0;

  quad_step_decoder #(.FILT_LEN(4), .X_MODE(4)) dut4 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .clr_err(clr_err),
    .step(step4), .dir(dir4), .err(err4), .err_sticky(errs4)
  );

  quad_step_decoder #(.FILT_LEN(4), .X_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .clr_err(clr_err),
    .step(step1), .dir(dir1), .err(err1), .err_sticky(errs1)
  );

  // Clock / cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor plus the downstream 4-bit up/down counter
  always @(negedge clk) begin
    if (step4) begin
      steps4++;
      last_step4 = cyc;
      q4 = dir4 ? q4 + 4'd1 : q4 - 4'd1;
    end
    if (err4) begin
      errcnt4++;
      last_err4 = cyc;
    end
    if (step1) steps1++;
    if (err1) errcnt1++;
    if (dut4.u_filt_a.filt) filt_a_seen = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    steps4 = 0; errcnt4 = 0; steps1 = 0; errcnt1 = 0;
    last_step4 = 0; last_err4 = 0; q4 = 4'd0; filt_a_seen = 1'b0;
  endtask

  task automatic do_reset(input logic a, input logic b);
    rst = 1'b1; a_in = a; b_in = b;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(14);
    clear_counts();
  endtask

  task automatic test_reset();
    wait_cycles(2);
    n_cmp++; if (step4 !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b want 0", step4); end
    n_cmp++; if (err4 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err4); end
    n_cmp++; if (errs4 !== 1'b0) begin n_fail++; $display("FAIL reset_err_sticky: got %b want 0", errs4); end
    n_cmp++; if (dir4 !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %b want 1", dir4); end
    n_cmp++; if (dir1 !== 1'b1) begin n_fail++; $display("FAIL reset_dir_x1: got %b want 1", dir1); end
  endtask

  task automatic test_forward();
    logic [1:0] seq [4];
    int k;
    seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      {a_in, b_in} = seq[i];
      k = cyc + 1;
      wait_cycles(12);
      n_cmp++; if (last_step4 - k !== 7) begin n_fail++; $display("FAIL fwd_latency[%0d]: got %0d want 7", i, last_step4 - k); end
      if (i == 2) begin
        n_cmp++; if (steps1 !== 0) begin n_fail++; $display("FAIL fwd_x1_early: got %0d want 0", steps1); end
      end
    end
    n_cmp++; if (steps4 !== 4) begin n_fail++; $display("FAIL fwd_steps: got %0d want 4", steps4); end
    n_cmp++; if (dir4 !== 1'b1) begin n_fail++; $display("FAIL fwd_dir: got %b want 1", dir4); end
    n_cmp++; if (errcnt4 !== 0) begin n_fail++; $display("FAIL fwd_err: got %0d want 0", errcnt4); end
    n_cmp++; if (q4 !== 4'h4) begin n_fail++; $display("FAIL fwd_counter: got %h want 4", q4); end
    n_cmp++; if (steps1 !== 1) begin n_fail++; $display("FAIL fwd_x1_steps: got %0d want 1", steps1); end
    n_cmp++; if (dir1 !== 1'b1) begin n_fail++; $display("FAIL fwd_x1_dir: got %b want 1", dir1); end
  endtask

  task automatic test_reverse();
    logic [1:0] seq [4];
    seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      {a_in, b_in} = seq[i];
      wait_cycles(12);
      if (i == 0) begin
        n_cmp++; if (dir4 !== 1'b0) begin n_fail++; $display("FAIL rev_dir_first: got %b want 0", dir4); end
        n_cmp++; if (steps1 !== 1) begin n_fail++; $display("FAIL rev_x1_first: got %0d want 1", steps1); end
      end
    end
    n_cmp++; if (steps4 !== 4) begin n_fail++; $display("FAIL rev_steps: got %0d want 4", steps4); end
    n_cmp++; if (q4 !== 4'hC) begin n_fail++; $display("FAIL rev_counter: got %h want c", q4); end
    n_cmp++; if (dir4 !== 1'b0) begin n_fail++; $display("FAIL rev_dir: got %b want 0", dir4); end
    n_cmp++; if (steps1 !== 1) begin n_fail++; $display("FAIL rev_x1_steps: got %0d want 1", steps1); end
    n_cmp++; if (dir1 !== 1'b0) begin n_fail++; $display("FAIL rev_x1_dir: got %b want 0", dir1); end
  endtask

  task automatic test_glitch();
    do_reset(1'b0, 1'b0);
    a_in = 1'b1;
    wait_cycles(3);
    a_in = 1'b0;
    wait_cycles(15);
    n_cmp++; if (steps4 !== 0) begin n_fail++; $display("FAIL glitch_steps: got %0d want 0", steps4); end
    n_cmp++; if (errcnt4 !== 0) begin n_fail++; $display("FAIL glitch_err: got %0d want 0", errcnt4); end
    n_cmp++; if (filt_a_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_filt_a: got %b want 0", filt_a_seen); end
    // A long B pulse is a real forward step followed by a reverse step
    b_in = 1'b1;
    wait_cycles(12);
    n_cmp++; if (dir4 !== 1'b1 || steps4 !== 1) begin n_fail++; $display("FAIL pulse_fwd: got dir %b steps %0d want 1/1", dir4, steps4); end
    b_in = 1'b0;
    wait_cycles(12);
    n_cmp++; if (dir4 !== 1'b0 || steps4 !== 2) begin n_fail++; $display("FAIL pulse_rev: got dir %b steps %0d want 0/2", dir4, steps4); end
  endtask

  task automatic test_illegal();
    int k;
    int c;
    clear_counts();
    a_in = 1'b1; b_in = 1'b1;
    k = cyc + 1;
    wait_cycles(12);
    n_cmp++; if (errcnt4 !== 1) begin n_fail++; $display("FAIL ill_err_count: got %0d want 1", errcnt4); end
    n_cmp++; if (last_err4 - k !== 7) begin n_fail++; $display("FAIL ill_latency: got %0d want 7", last_err4 - k); end
    n_cmp++; if (errs4 !== 1'b1 || errs1 !== 1'b1) begin n_fail++; $display("FAIL ill_sticky: got %b/%b want 1/1", errs4, errs1); end
    n_cmp++; if (steps4 !== 0) begin n_fail++; $display("FAIL ill_steps: got %0d want 0", steps4); end
    n_cmp++; if (dir4 !== 1'b0) begin n_fail++; $display("FAIL ill_dir: got %b want 0", dir4); end
    clr_err = 1'b1;
    wait_cycles(1);
    clr_err = 1'b0;
    n_cmp++; if (errs4 !== 1'b0) begin n_fail++; $display("FAIL clr_sticky: got %b want 0", errs4); end
    // Land clr_err on the same edge as a fresh error
    a_in = 1'b0; b_in = 1'b0;
    c = cyc;
    wait_cycles(7);
    clr_err = 1'b1;
    wait_cycles(1);
    clr_err = 1'b0;
    n_cmp++; if (err4 !== 1'b1 || errs4 !== 1'b1) begin n_fail++; $display("FAIL clr_vs_set: got err %b sticky %b want 1/1 (cyc %0d)", err4, errs4, cyc - c); end
    wait_cycles(4);
  endtask

  task automatic test_settle_nonzero();
    rst = 1'b1; a_in = 1'b1; b_in = 1'b1;
    wait_cycles(3);
    clear_counts();
    rst = 1'b0;
    wait_cycles(20);
    n_cmp++; if (steps4 !== 0 || steps1 !== 0) begin n_fail++; $display("FAIL settle_steps: got %0d/%0d want 0/0", steps4, steps1); end
    n_cmp++; if (errcnt4 !== 0 || errs4 !== 1'b0) begin n_fail++; $display("FAIL settle_err: got %0d sticky %b want 0/0", errcnt4, errs4); end
    b_in = 1'b0;
    wait_cycles(12);
    n_cmp++; if (steps4 !== 1 || dir4 !== 1'b1) begin n_fail++; $display("FAIL settle_move: got steps %0d dir %b want 1/1", steps4, dir4); end
    n_cmp++; if (steps1 !== 0) begin n_fail++; $display("FAIL settle_move_x1: got %0d want 0", steps1); end
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0, 1'b0);
    a_in = 1'b1; b_in = 1'b1;
    wait_cycles(12);
    a_in = 1'b0;
    wait_cycles(12);
    n_cmp++; if (errs1 !== 1'b1 || dir1 !== 1'b0) begin n_fail++; $display("FAIL pre_reset_x1: got sticky %b dir %b want 1/0", errs1, dir1); end
    b_in = 1'b0;
    wait_cycles(12);
    // 00->10 would pulse the X1 step on the very edge that samples rst
    a_in = 1'b1;
    wait_cycles(7);
    rst = 1'b1;
    wait_cycles(1);
    n_cmp++; if (step1 !== 1'b0 || err1 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_pulse: got step %b err %b want 0/0", step1, err1); end
    n_cmp++; if (errs1 !== 1'b0 || dir1 !== 1'b1) begin n_fail++; $display("FAIL mid_reset_flags: got sticky %b dir %b want 0/1", errs1, dir1); end
    n_cmp++; if (steps1 !== 0) begin n_fail++; $display("FAIL mid_reset_x1_count: got %0d want 0", steps1); end
    n_cmp++; if (errs4 !== 1'b0 || dir4 !== 1'b1) begin n_fail++; $display("FAIL mid_reset_x4: got sticky %b dir %b want 0/1", errs4, dir4); end
    rst = 1'b0;
    wait_cycles(2);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_illegal();
    test_settle_nonzero();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
